// File: rtl/apb_pkg.sv
// Shared definitions for the APB initiator: FSM state encoding, default bus
// widths and the read-data pattern returned when a transfer times out.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    localparam int          APB_ADDR_W       = 32;
    localparam int          APB_DATA_W       = 32;
    localparam logic [31:0] APB_TIMEOUT_DATA = 32'hDEAD_BEEF;

endpackage : apb_pkg

// File: rtl/apb_master_ctrl.sv
// APB3 initiator: valid/ready command in, SETUP/ACCESS on the bus, held response out.
// Optional ACCESS-phase timeout is enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master_ctrl
    import apb_pkg::*;
#(
    parameter int ADDR_W         = APB_ADDR_W,
    parameter int DATA_W         = APB_DATA_W,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              M_PSELx,
    output logic              M_PENABLE,
    output logic [ADDR_W-1:0] M_PADDR,
    output logic [DATA_W-1:0] M_PWDATA,
    output logic              M_PWRITE,
    input  logic [DATA_W-1:0] M_PRDATA,
    input  logic              M_PREADY,
    input  logic              M_PSLVERR
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("apb_master_ctrl: TIMEOUT_CYCLES must be >= 1");
    end

    apb_state_e        state_r;
    apb_state_e        next_state_s;
    logic              accept_s;
    logic              done_s;
    logic              timeout_s;
    logic              timeout_hit_s;

    logic              cmd_ready_r;
    logic              rsp_valid_r;
    logic [DATA_W-1:0] rsp_rdata_r;
    logic              rsp_err_r;
    logic              psel_r;
    logic              penable_r;
    logic [ADDR_W-1:0] paddr_r;
    logic [DATA_W-1:0] pwdata_r;
    logic              pwrite_r;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int TO_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    // The counter holds the number of wait cycles already spent, so the
    // TIMEOUT_CYCLES-th ACCESS cycle is the last one granted to the slave.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] to_cnt_r;

    // Wait-state counter: cleared in SETUP, counts stalled ACCESS cycles.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            to_cnt_r <= {TO_W{1'b0}};
        end else if (state_r == SETUP) begin
            to_cnt_r <= {TO_W{1'b0}};
        end else if ((state_r == ACCESS) && !M_PREADY) begin
            to_cnt_r <= to_cnt_r + TO_W'(1);
        end else begin
            to_cnt_r <= to_cnt_r;
        end
    end

    assign timeout_hit_s = (to_cnt_r == TO_LAST);
`else
    assign timeout_hit_s = 1'b0;
`endif

    // Next-state decode; PREADY/PSLVERR only matter while in ACCESS.
    always_comb begin
        next_state_s = state_r;
        accept_s     = 1'b0;
        done_s       = 1'b0;
        timeout_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (cmd_valid && cmd_ready_r) begin
                    accept_s     = 1'b1;
                    next_state_s = SETUP;
                end else begin
                    next_state_s = IDLE;
                end
            end
            SETUP: begin
                next_state_s = ACCESS;
            end
            ACCESS: begin
                if (M_PREADY) begin
                    done_s       = 1'b1;
                    next_state_s = RESP;
                end else if (timeout_hit_s) begin
                    timeout_s    = 1'b1;
                    next_state_s = RESP;
                end else begin
                    next_state_s = ACCESS;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = RESP;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State register and state-derived control outputs, registered from next state.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_r     <= IDLE;
            cmd_ready_r <= 1'b0;
            psel_r      <= 1'b0;
            penable_r   <= 1'b0;
            rsp_valid_r <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            cmd_ready_r <= (next_state_s == IDLE);
            psel_r      <= (next_state_s == SETUP) || (next_state_s == ACCESS);
            penable_r   <= (next_state_s == ACCESS);
            rsp_valid_r <= (next_state_s == RESP);
        end
    end

    // Address/data/direction are only updated on acceptance, keeping the idle bus quiet.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            paddr_r  <= {ADDR_W{1'b0}};
            pwdata_r <= {DATA_W{1'b0}};
            pwrite_r <= 1'b0;
        end else if (accept_s) begin
            paddr_r  <= cmd_addr;
            pwdata_r <= cmd_wdata;
            pwrite_r <= cmd_write;
        end else begin
            paddr_r  <= paddr_r;
            pwdata_r <= pwdata_r;
            pwrite_r <= pwrite_r;
        end
    end

    // Response capture on completion (or abort); held through RESP.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rsp_rdata_r <= {DATA_W{1'b0}};
            rsp_err_r   <= 1'b0;
        end else if (done_s) begin
            rsp_rdata_r <= pwrite_r ? {DATA_W{1'b0}} : M_PRDATA;
            rsp_err_r   <= M_PSLVERR;
        end else if (timeout_s) begin
`ifdef APB_MASTER_TIMEOUT_EN
            rsp_rdata_r <= DATA_W'(APB_TIMEOUT_DATA);
`else
            rsp_rdata_r <= rsp_rdata_r;
`endif
            rsp_err_r   <= 1'b1;
        end else begin
            rsp_rdata_r <= rsp_rdata_r;
            rsp_err_r   <= rsp_err_r;
        end
    end

    assign cmd_ready = cmd_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_err   = rsp_err_r;
    assign M_PSELx   = psel_r;
    assign M_PENABLE = penable_r;
    assign M_PADDR   = paddr_r;
    assign M_PWDATA  = pwdata_r;
    assign M_PWRITE  = pwrite_r;

endmodule : apb_master_ctrl

// File: tb/tb_apb_master_ctrl.sv
// Directed self-checking bench for apb_master_ctrl; the bench plays the APB slave.
module tb_apb_master_ctrl;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              PCLK;
    logic              PRESETn;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              M_PSELx;
    logic              M_PENABLE;
    logic [ADDR_W-1:0] M_PADDR;
    logic [DATA_W-1:0] M_PWDATA;
    logic              M_PWRITE;
    logic [DATA_W-1:0] M_PRDATA;
    logic              M_PREADY;
    logic              M_PSLVERR;

    int n_checks = 0;
    int n_fail   = 0;

    apb_master_ctrl #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .PCLK(PCLK),
        .PRESETn(PRESETn),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .M_PSELx(M_PSELx),
        .M_PENABLE(M_PENABLE),
        .M_PADDR(M_PADDR),
        .M_PWDATA(M_PWDATA),
        .M_PWRITE(M_PWRITE),
        .M_PRDATA(M_PRDATA),
        .M_PREADY(M_PREADY),
        .M_PSLVERR(M_PSLVERR)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    task automatic check_bus(input string tag, input logic sel, input logic en);
        check_val({tag, ".psel"}, 64'(M_PSELx), 64'(sel));
        check_val({tag, ".penable"}, 64'(M_PENABLE), 64'(en));
    endtask

    initial begin
        PRESETn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 32'h0;
        cmd_wdata = 32'h0;
        rsp_ready = 1'b0;
        M_PRDATA  = 32'h0;
        M_PREADY  = 1'b0;
        M_PSLVERR = 1'b0;

        // Reset state
        repeat (3) step();
        check_val("rst.cmd_ready", 64'(cmd_ready), 64'h0);
        check_val("rst.rsp_valid", 64'(rsp_valid), 64'h0);
        check_val("rst.rsp_rdata", 64'(rsp_rdata), 64'h0);
        check_val("rst.paddr", 64'(M_PADDR), 64'h0);
        check_bus("rst", 1'b0, 1'b0);
        PRESETn = 1'b1;
        check_val("rel.cmd_ready_low", 64'(cmd_ready), 64'h0);
        step();
        check_val("rel.cmd_ready_high", 64'(cmd_ready), 64'h1);

        // Read, zero wait states; PREADY high early must not matter in SETUP
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h40; cmd_wdata = 32'h7777_7777;
        M_PREADY = 1'b1; M_PRDATA = 32'h1234_5678;
        step();
        cmd_valid = 1'b0;
        check_bus("rd.setup", 1'b1, 1'b0);
        check_val("rd.setup.cmd_ready", 64'(cmd_ready), 64'h0);
        check_val("rd.paddr", 64'(M_PADDR), 64'h40);
        check_val("rd.pwrite", 64'(M_PWRITE), 64'h0);
        check_val("rd.setup.rsp_valid", 64'(rsp_valid), 64'h0);
        step();
        check_bus("rd.access", 1'b1, 1'b1);
        step();
        check_bus("rd.resp", 1'b0, 1'b0);
        check_val("rd.rsp_valid", 64'(rsp_valid), 64'h1);
        check_val("rd.rsp_rdata", 64'(rsp_rdata), 64'h1234_5678);
        check_val("rd.rsp_err", 64'(rsp_err), 64'h0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check_val("rd.idle.rsp_valid", 64'(rsp_valid), 64'h0);
        check_val("rd.idle.cmd_ready", 64'(cmd_ready), 64'h1);
        check_val("rd.idle.paddr_held", 64'(M_PADDR), 64'h40);

        // Write with 3 wait states
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h80; cmd_wdata = 32'hA5A5_A5A5;
        M_PREADY = 1'b0; M_PRDATA = 32'hFFFF_FFFF;
        step();
        cmd_valid = 1'b0; cmd_addr = 32'h0; cmd_wdata = 32'h0;
        check_bus("wr.setup", 1'b1, 1'b0);
        check_val("wr.pwrite", 64'(M_PWRITE), 64'h1);
        step();
        for (int i = 0; i < 3; i++) begin
            check_bus("wr.wait", 1'b1, 1'b1);
            check_val("wr.wait.paddr", 64'(M_PADDR), 64'h80);
            check_val("wr.wait.pwdata", 64'(M_PWDATA), 64'hA5A5_A5A5);
            check_val("wr.wait.rsp_valid", 64'(rsp_valid), 64'h0);
            step();
        end
        check_bus("wr.access4", 1'b1, 1'b1);
        M_PREADY = 1'b1;
        step();
        check_val("wr.rsp_valid", 64'(rsp_valid), 64'h1);
        check_val("wr.rsp_rdata", 64'(rsp_rdata), 64'h0);
        check_val("wr.rsp_err", 64'(rsp_err), 64'h0);
        check_bus("wr.resp", 1'b0, 1'b0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;

        // Slave error on a read
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'hC0;
        M_PREADY = 1'b1; M_PSLVERR = 1'b1; M_PRDATA = 32'hCAFE_0001;
        step();
        cmd_valid = 1'b0;
        step();
        step();
        check_val("err.rsp_valid", 64'(rsp_valid), 64'h1);
        check_val("err.rsp_err", 64'(rsp_err), 64'h1);
        check_val("err.rsp_rdata", 64'(rsp_rdata), 64'hCAFE_0001);

        // Back-pressure: second command held while response waits
        M_PSLVERR = 1'b0; M_PRDATA = 32'h5555_AAAA;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h44;
        for (int i = 0; i < 10; i++) begin
            check_val("bp.cmd_ready", 64'(cmd_ready), 64'h0);
            check_val("bp.rsp_valid", 64'(rsp_valid), 64'h1);
            check_val("bp.rsp_rdata", 64'(rsp_rdata), 64'hCAFE_0001);
            check_val("bp.rsp_err", 64'(rsp_err), 64'h1);
            check_val("bp.psel", 64'(M_PSELx), 64'h0);
            step();
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check_val("bp.idle.rsp_valid", 64'(rsp_valid), 64'h0);
        check_val("bp.idle.cmd_ready", 64'(cmd_ready), 64'h1);
        check_bus("bp.idle", 1'b0, 1'b0);
        M_PREADY = 1'b0;
        step();
        cmd_valid = 1'b0;
        check_bus("bp.setup2", 1'b1, 1'b0);
        check_val("bp.paddr2", 64'(M_PADDR), 64'h44);

        // Reset in the middle of ACCESS
        step();
        check_bus("rstmid.access", 1'b1, 1'b1);
        #2;
        PRESETn = 1'b0;
        #1;
        check_bus("rstmid.async", 1'b0, 1'b0);
        check_val("rstmid.rsp_valid", 64'(rsp_valid), 64'h0);
        check_val("rstmid.cmd_ready", 64'(cmd_ready), 64'h0);
        check_val("rstmid.rsp_rdata", 64'(rsp_rdata), 64'h0);
        step();
        PRESETn = 1'b1;
        step();
        check_val("rstmid.rel.cmd_ready", 64'(cmd_ready), 64'h1);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h10; cmd_wdata = 32'h0BAD_F00D;
        M_PREADY = 1'b1;
        step();
        cmd_valid = 1'b0;
        check_val("post.pwdata", 64'(M_PWDATA), 64'h0BAD_F00D);
        step();
        step();
        check_val("post.rsp_valid", 64'(rsp_valid), 64'h1);
        check_val("post.rsp_rdata", 64'(rsp_rdata), 64'h0);
        check_val("post.rsp_err", 64'(rsp_err), 64'h0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check_val("post.done", 64'(rsp_valid), 64'h0);

`ifdef APB_MASTER_TIMEOUT_EN
        // Timeout after 4 stalled ACCESS cycles
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h100;
        M_PREADY = 1'b0;
        step();
        cmd_valid = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            check_bus("to.wait", 1'b1, 1'b1);
            check_val("to.wait.rsp_valid", 64'(rsp_valid), 64'h0);
            step();
        end
        check_bus("to.access4", 1'b1, 1'b1);
        step();
        check_bus("to.resp", 1'b0, 1'b0);
        check_val("to.rsp_valid", 64'(rsp_valid), 64'h1);
        check_val("to.rsp_err", 64'(rsp_err), 64'h1);
        check_val("to.rsp_rdata", 64'(rsp_rdata), 64'hDEAD_BEEF);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_apb_master_ctrl
